// File: rtl/mcu_pkg.sv
// mcu_pkg: shared states, opcode/func constants and select encodings for the multicycle control unit.
// The JUMP state exists only when MCU_JUMP_EN is defined.
package mcu_pkg;
  typedef enum logic [3:0] {
    RST_IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, EXEC_LUI, WB_I
`ifdef MCU_JUMP_EN
    , JUMP
`endif
  } mcuState;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_LUI = 6'b001111, OP_J = 6'b000010;
  localparam logic [5:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010, FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR = 6'b100101, FN_XOR = 6'b100110;
  localparam logic [2:0] ALU_AND = 3'b000, ALU_OR = 3'b001, ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011, ALU_LUI = 3'b100, ALU_SUB = 3'b110;
  localparam logic [1:0] SRCB_REG = 2'b00, SRCB_FOUR = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH = 2'b11;
  localparam logic [1:0] PC_ALU = 2'b00, PC_ALUOUT = 2'b01, PC_JUMP = 2'b10;
endpackage

// File: rtl/mcu_alu_decode.sv
// mcu_alu_decode: maps an R-type func field to a 3-bit ALU code and flags supported encodings.
module mcu_alu_decode
  import mcu_pkg::*;
(
  input  logic [5:0] func,
  output logic [2:0] aluCode,
  output logic       legal
);
  always_comb begin
    aluCode = ALU_ADD;
    legal = 1'b1;
    case (func)
      FN_ADD: aluCode = ALU_ADD;
      FN_SUB: aluCode = ALU_SUB;
      FN_AND: aluCode = ALU_AND;
      FN_OR:  aluCode = ALU_OR;
      FN_XOR: aluCode = ALU_XOR;
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FSM sequencing MIPS instructions through fetch/decode/execute/memory/write-back.
// Define MCU_JUMP_EN to support the j instruction (op 000010); otherwise it decodes as illegal.
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                IRWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [1:0]          PCSrc,
  output logic [ALU_OP_W-1:0] ALU_op,
  output logic                instr_done,
  output logic                illegal
);
  mcuState state, nextState;
  logic [5:0] opReg, funcReg;
  logic [2:0] rCode, aluCode;
  logic rLegal;
  logic unusedZero;
  // The branch decision is made in the datapath from PCWriteCond and zero.
  assign unusedZero = zero;
  // In DECODE the IR func is checked live; afterwards the latched copy drives EXEC_R.
  mcu_alu_decode uDec (
    .func(state == DECODE ? func : funcReg),
    .aluCode(rCode),
    .legal(rLegal)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RST_IDLE;
      opReg <= '0;
      funcReg <= '0;
    end else begin
      state <= nextState;
      if (state == DECODE) begin
        opReg <= op;
        funcReg <= func;
      end
    end
  end
  assign ALU_op = ALU_OP_W'(aluCode);
  always_comb begin
    nextState = state;
    aluCode = ALU_AND;
    {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA} = '0;
    ALUSrcB = SRCB_REG;
    PCSrc = PC_ALU;
    instr_done = 1'b0;
    illegal = 1'b0;
    case (state)
      RST_IDLE: nextState = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        aluCode = ALU_ADD;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        nextState = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = SRCB_IMM_SH;
        aluCode = ALU_ADD;
        nextState = FETCH;
        if (op == OP_R && rLegal) nextState = EXEC_R;
        else if (op == OP_LW || op == OP_SW) nextState = ADDR;
        else if (op == OP_BEQ) nextState = BRANCH;
        else if (op == OP_LUI) nextState = EXEC_LUI;
`ifdef MCU_JUMP_EN
        else if (op == OP_J) nextState = JUMP;
`endif
        illegal = nextState == FETCH;
        instr_done = nextState == FETCH;
      end
      EXEC_R: begin
        ALUSrcA = 1'b1;
        aluCode = rCode;
        nextState = WB_R;
      end
      WB_R: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        aluCode = ALU_ADD;
        nextState = opReg == OP_SW ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nextState = mem_ready ? WB_MEM : MEM_RD;
      end
      WB_MEM: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      MEM_WR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        instr_done = mem_ready;
        nextState = mem_ready ? FETCH : MEM_WR;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        aluCode = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSrc = PC_ALUOUT;
        instr_done = 1'b1;
        nextState = FETCH;
      end
      EXEC_LUI: begin
        ALUSrcB = SRCB_IMM;
        aluCode = ALU_LUI;
        nextState = WB_I;
      end
      WB_I: begin
        RegWrite = 1'b1;
        instr_done = 1'b1;
        nextState = FETCH;
      end
`ifdef MCU_JUMP_EN
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc = PC_JUMP;
        instr_done = 1'b1;
        nextState = FETCH;
      end
`endif
      default: nextState = RST_IDLE;
    endcase
  end
endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle MIPS control decoder: an FSM that sequences each instruction through fetch, decode, execute, memory and write-back cycles. It drives the shared-memory datapath (PC, IR, register file, ALU, unified memory). It supports memory wait states through a `mem_ready` handshake and reports per-instruction completion and illegal encodings. The ALU control width is parametrised.

## Interface
- `ALU_OP_W`, default 3: width of `ALU_op`. Must be ≥ 3; codes are zero-extended.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `op` input 6: IR[31:26]. Valid from DECODE onward.
- `func` input 6: IR[5:0]. Valid from DECODE onward.
- `zero` input 1: ALU zero flag, used in BRANCH.
- `mem_ready` input 1: memory completes the access this cycle.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `ALUSrcA` output 1 each: datapath controls.
- `ALUSrcB` output 2: ALU B select. 00 = reg B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `PCSrc` output 2: PC source select. 00 = ALU, 01 = ALUOut, 10 = jump target.
- `ALU_op` output ALU_OP_W: ALU function code.
- `instr_done` output 1: one-cycle pulse in the final cycle of each instruction.
- `illegal` output 1: one-cycle pulse in DECODE for an unsupported op or func.

## Operation
- ALU codes: AND = 000, OR = 001, ADD = 010, XOR = 011, LUI = 100 (B << 16), SUB = 110.
- States: RST_IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_MEM, MEM_WR, BRANCH, EXEC_LUI, WB_I, JUMP (JUMP only with the macro).
- RST_IDLE: all outputs 0. Goes to FETCH on the next clock.
- FETCH:
  - Asserts MemRead, ALUSrcA = 0, ALUSrcB = 01, ALU_op = ADD, PCSrc = 00, IorD = 0.
  - IRWrite and PCWrite are asserted only in the cycle where `mem_ready` = 1; the FSM then goes to DECODE.
  - Otherwise the FSM holds in FETCH.
- DECODE:
  - Computes the branch target: ALUSrcA = 0, ALUSrcB = 11, ALU_op = ADD.
  - Latches op/func internally.
  - Dispatch:
    - op 000000 with func 100000 / 100010 / 100100 / 100101 / 100110 → EXEC_R.
    - 100011 or 101011 → ADDR.
    - 000100 → BRANCH.
    - 001111 → EXEC_LUI.
    - Anything else: pulse `illegal` and `instr_done`, return to FETCH.
- EXEC_R: ALUSrcA = 1, ALUSrcB = 00, ALU_op from func (ADD / SUB / AND / OR / XOR).
- WB_R: RegDst = 1, RegWrite = 1, MemtoReg = 0, `instr_done`.
- ADDR: ALUSrcA = 1, ALUSrcB = 10, ALU_op = ADD. Goes to MEM_RD for lw, MEM_WR for sw.
- MEM_RD: MemRead = 1, IorD = 1. Holds until `mem_ready`, then goes to WB_MEM.
- WB_MEM: RegDst = 0, MemtoReg = 1, RegWrite = 1, `instr_done`.
- MEM_WR: MemWrite = 1, IorD = 1. Holds until `mem_ready`; `instr_done` in the accepting cycle.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALU_op = SUB, PCWriteCond = 1, PCSrc = 01, `instr_done`.
- EXEC_LUI: ALUSrcB = 10, ALU_op = LUI.
- WB_I: RegDst = 0, MemtoReg = 0, RegWrite = 1, `instr_done`.
- All non-terminal states return to FETCH after their final cycle.
- Unlisted outputs are 0 in every state.

## Timing
- Outputs are combinational from the state register and the latched op/func; no output is registered.
- Minimum cycles with `mem_ready` always 1: R-type 4, lw 5, sw 4, beq 3, lui 4, j 3. Each wait cycle adds 1.
- MemRead/MemWrite stay asserted, and IorD stays stable, for the whole wait.
- Reset asserted at any time, including mid-wait:
  - State goes immediately to RST_IDLE and every output drops to 0 asynchronously.
  - No partial write occurs: RegWrite and MemWrite are forced to 0.
- `mem_ready` outside FETCH/MEM_RD/MEM_WR is ignored.
- `instr_done` and `illegal` never assert in RST_IDLE.

## Configuration
- `MCU_JUMP_EN` defined:
  - op 000010 dispatches from DECODE to JUMP.
  - JUMP: PCWrite = 1, PCSrc = 10, `instr_done`, then FETCH.
- `MCU_JUMP_EN` undefined: op 000010 is illegal, and the JUMP state and PCSrc = 10 are never produced.

## Structure
- Package `mcu_pkg`: state enum, opcode constants (R, LW, SW, BEQ, LUI, J), func constants, 3-bit ALU code constants, ALUSrcB/PCSrc select encodings.
- Sub-module `mcu_alu_decode`: combinational func → ALU code mapping plus an R-type legal flag. Used by EXEC_R and by DECODE for legality.

## Test plan
- Reset, then run add (op 000000, func 100000) with `mem_ready` = 1 → states FETCH, DECODE, EXEC_R, WB_R; ALU_op = 010 in EXEC_R; RegWrite = 1 and RegDst = 1 in cycle 4 with `instr_done`.
- lw (100011) with `mem_ready` low for 2 cycles in MEM_RD → 7 cycles total; MemRead and IorD = 1 held throughout; RegWrite = 1 and MemtoReg = 1 in WB_MEM only.
- sw (101011), then beq (000100) with `zero` = 1 → MemWrite = 1 only in MEM_WR; PCWriteCond = 1, PCSrc = 01, ALU_op = 110 in BRANCH; beq completes in 3 cycles.
- lui (001111), then illegal op 111111 → ALU_op = 100, then RegWrite = 1 and RegDst = 0 in WB_I; for 111111, `illegal` and `instr_done` pulse in DECODE and FETCH follows.
- Assert `rst` mid-MEM_WR while `mem_ready` = 0 → all outputs 0 the same cycle; RST_IDLE for one cycle after release; FETCH follows.
- op 000010 → with `MCU_JUMP_EN`: JUMP with PCWrite = 1 and PCSrc = 10 (3 cycles); without it: `illegal` pulse.
